// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid geometry, block encodings and the
// food placer state type.
package snake_pkg;

  localparam int unsigned GRID_HEIGHT    = 24;
  localparam int unsigned GRID_WIDTH     = 32;
  localparam int unsigned BITS_PER_BLOCK = 2;

  localparam int unsigned BLOCK_EMPTY = 0;
  localparam int unsigned BLOCK_WALL  = 1;
  localparam int unsigned BLOCK_SNAKE = 2;
  localparam int unsigned BLOCK_FOOD  = 3;

  // The SCAN_* states are only reachable in the scan-fallback build.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_SCAN_LOOKUP,
    ST_SCAN_CHECK
  } placer_state_e;

endpackage

// File: rtl/food_scan_step.sv
// Combinational step to the next interior grid cell in row-major order,
// wrapping column then row, with a flag for arriving back at a start cell.
module food_scan_step
  import snake_pkg::*;
(
  input  logic [$clog2(GRID_HEIGHT)-1:0] i_cur_v,
  input  logic [$clog2(GRID_WIDTH)-1:0]  i_cur_h,
  input  logic [$clog2(GRID_HEIGHT)-1:0] i_start_v,
  input  logic [$clog2(GRID_WIDTH)-1:0]  i_start_h,
  output logic [$clog2(GRID_HEIGHT)-1:0] o_nxt_v,
  output logic [$clog2(GRID_WIDTH)-1:0]  o_nxt_h,
  output logic                           o_at_start
);

  localparam int unsigned VW = $clog2(GRID_HEIGHT);
  localparam int unsigned HW = $clog2(GRID_WIDTH);

  always_comb begin
    o_nxt_v = i_cur_v;
    o_nxt_h = i_cur_h + HW'(1);
    if (i_cur_h >= HW'(GRID_WIDTH - 2)) begin
      o_nxt_h = HW'(1);
      if (i_cur_v >= VW'(GRID_HEIGHT - 2)) o_nxt_v = VW'(1);
      else                                 o_nxt_v = i_cur_v + VW'(1);
    end
  end

  assign o_at_start = (o_nxt_v == i_start_v) && (o_nxt_h == i_start_h);

endmodule

// File: rtl/food_placer.sv
// Food placer: draws random candidates, checks them against the grid RAM and
// writes BLOCK_FOOD into the first empty interior cell found.
// Optional macro FOOD_PLACER_SCAN_FALLBACK_EN adds a linear-scan fallback
// after MAX_TRIES rejected candidates and reports GridFull.
module food_placer
  import snake_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic                            MasterClock,
  input  logic                            Reset,
  input  logic                            PlaceReq,
  input  logic [$clog2(GRID_HEIGHT)-1:0]  CandV,
  input  logic [$clog2(GRID_WIDTH)-1:0]   CandH,
  output logic [$clog2(GRID_HEIGHT)-1:0]  RdV,
  output logic [$clog2(GRID_WIDTH)-1:0]   RdH,
  input  logic [BITS_PER_BLOCK-1:0]       RdData,
  output logic                            WrEn,
  output logic [$clog2(GRID_HEIGHT)-1:0]  WrV,
  output logic [$clog2(GRID_WIDTH)-1:0]   WrH,
  output logic [BITS_PER_BLOCK-1:0]       WrData,
  output logic [$clog2(GRID_HEIGHT)-1:0]  FoodV,
  output logic [$clog2(GRID_WIDTH)-1:0]   FoodH,
  output logic                            Busy,
  output logic                            Done,
  output logic                            GridFull
);

  localparam int unsigned VW = $clog2(GRID_HEIGHT);
  localparam int unsigned HW = $clog2(GRID_WIDTH);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  placer_state_e   r_state;
  placer_state_e   w_state_nxt;
  logic [TW-1:0]   r_tries;
  logic [TW-1:0]   w_tries_inc;
  logic [VW-1:0]   r_cur_v;
  logic [HW-1:0]   r_cur_h;
  logic            w_cand_int;
  logic            w_empty;

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
  logic [VW-1:0]   r_start_v;
  logic [HW-1:0]   r_start_h;
  logic [VW-1:0]   w_nxt_v;
  logic [HW-1:0]   w_nxt_h;
  logic            w_at_start;
  logic            w_fallback;
  logic            r_grid_full;

  food_scan_step u_scan_step (
    .i_cur_v    (r_cur_v),
    .i_cur_h    (r_cur_h),
    .i_start_v  (r_start_v),
    .i_start_h  (r_start_h),
    .o_nxt_v    (w_nxt_v),
    .o_nxt_h    (w_nxt_h),
    .o_at_start (w_at_start)
  );

  assign w_fallback = (w_tries_inc == TW'(MAX_TRIES));
  assign GridFull   = r_grid_full;
`else
  assign GridFull = 1'b0;
`endif

  assign w_cand_int = (CandV >= VW'(1)) && (CandV <= VW'(GRID_HEIGHT - 2)) &&
                      (CandH >= HW'(1)) && (CandH <= HW'(GRID_WIDTH - 2));
  assign w_empty    = (RdData == BITS_PER_BLOCK'(BLOCK_EMPTY));
  assign w_tries_inc = (r_tries == TW'(MAX_TRIES)) ? r_tries : r_tries + TW'(1);

  always_ff @(posedge MasterClock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (PlaceReq) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (w_cand_int) w_state_nxt = ST_LOOKUP;
      ST_LOOKUP: w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_empty) w_state_nxt = ST_WRITE;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        else if (w_fallback) w_state_nxt = ST_SCAN_LOOKUP;
`endif
        else w_state_nxt = ST_SAMPLE;
      end
      ST_WRITE:  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
      ST_SCAN_LOOKUP: w_state_nxt = ST_SCAN_CHECK;
      ST_SCAN_CHECK: begin
        if (w_empty)         w_state_nxt = ST_WRITE;
        else if (w_at_start) w_state_nxt = ST_DONE;
        else                 w_state_nxt = ST_SCAN_LOOKUP;
      end
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and write port are registered from the next state so every
  // output comes straight from a flop.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      r_tries  <= '0;
      r_cur_v  <= '0;
      r_cur_h  <= '0;
      RdV      <= '0;
      RdH      <= '0;
      WrEn     <= 1'b0;
      WrV      <= '0;
      WrH      <= '0;
      WrData   <= '0;
      FoodV    <= '0;
      FoodH    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
      r_start_v   <= '0;
      r_start_h   <= '0;
      r_grid_full <= 1'b0;
`endif
    end else begin
      WrEn   <= (w_state_nxt == ST_WRITE);
      Done   <= (w_state_nxt == ST_DONE);
      Busy   <= (w_state_nxt != ST_IDLE);
      WrData <= (w_state_nxt == ST_WRITE) ? BITS_PER_BLOCK'(BLOCK_FOOD) : '0;
      if (w_state_nxt == ST_WRITE) begin
        WrV   <= r_cur_v;
        WrH   <= r_cur_h;
        FoodV <= r_cur_v;
        FoodH <= r_cur_h;
      end
      case (r_state)
        ST_IDLE: begin
          if (PlaceReq) begin
            r_tries <= '0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            r_grid_full <= 1'b0;
`endif
          end
        end
        ST_SAMPLE: begin
          r_cur_v <= CandV;
          r_cur_h <= CandH;
          RdV     <= CandV;
          RdH     <= CandH;
          if (!w_cand_int) r_tries <= w_tries_inc;
        end
        ST_CHECK: begin
          if (!w_empty) begin
            r_tries <= w_tries_inc;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            // Scan starts one past the rejected cell; that cell marks the end.
            if (w_fallback) begin
              r_start_v <= r_cur_v;
              r_start_h <= r_cur_h;
              r_cur_v   <= w_nxt_v;
              r_cur_h   <= w_nxt_h;
              RdV       <= w_nxt_v;
              RdH       <= w_nxt_h;
            end
`endif
          end
        end
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        ST_SCAN_CHECK: begin
          if (!w_empty) begin
            if (w_at_start) begin
              r_grid_full <= 1'b1;
            end else begin
              r_cur_v <= w_nxt_v;
              r_cur_h <= w_nxt_h;
              RdV     <= w_nxt_v;
              RdH     <= w_nxt_h;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
